// File: rtl/aes_result_checker.sv
// -----------------------------------------------------------------------------
// aes_result_checker
//
// Self-check stage behind the SPI master of the AES board build. A start pulse
// arms the checker, which then waits for the 128-bit result word from the SIPO
// register. The captured word is compared against EXPECTED. The number of
// differing bits is reported on err_bits. Three board LEDs show the outcome:
// pass, fail, and busy-blink / steady timeout. A hang upstream therefore shows
// up as a visible timeout instead of a dark board.
//
// Parameters
//   EXPECTED       : expected 128-bit result word
//   TIMEOUT_CYCLES : cycles to wait for result_valid after arming (2..2^20)
//   BLINK_DIV      : blink counter width; led3 toggles every 2^(BLINK_DIV-1)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-low reset
//   start        in   one-cycle arm / re-arm pulse
//   result       in   128-bit result word, sampled on result_valid
//   result_valid in   one-cycle strobe qualifying result
//   done         out  high in PASS, FAIL or TIMEOUT
//   pass         out  high only in PASS
//   err_bits     out  popcount(result ^ EXPECTED) at the last capture
//   led1         out  pass indicator
//   led2         out  fail indicator
//   led3         out  busy blink while waiting, steady on at timeout
// -----------------------------------------------------------------------------
module aes_result_checker #(
    parameter logic [127:0] EXPECTED       = 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    parameter int           TIMEOUT_CYCLES = 4096,
    parameter int           BLINK_DIV      = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] result,
    input  logic         result_valid,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_bits,
    output logic         led1,
    output logic         led2,
    output logic         led3
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    // The timeout decision looks at the count before the edge. Comparing
    // against TIMEOUT_CYCLES-2 makes done rise on the edge where the count
    // would reach TIMEOUT_CYCLES-1. That edge is N+TIMEOUT_CYCLES-1 for an
    // arm at edge N.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    // Number of set bits in a 128-bit word; the 8-bit sum tops out at 128.
    function automatic logic [7:0] popcount128(input logic [127:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < 128; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

    state_t                 state_r, state_s;
    logic [TW-1:0]          to_cnt_r, to_cnt_s;
    logic [BLINK_DIV-1:0]   blink_r, blink_s;
    logic [7:0]             err_bits_r, err_bits_s;
    logic                   done_r, done_s;
    logic                   pass_r, pass_s;
    logic                   led1_r, led1_s;
    logic                   led2_r, led2_s;
    logic                   led3_r, led3_s;
    logic [7:0]             diff_pop_s;

    assign diff_pop_s = popcount128(result ^ EXPECTED);

    // Next-state, counter and output decode; outputs follow the next state so they leave the block registered.
    always_comb begin
        state_s    = state_r;
        to_cnt_s   = to_cnt_r;
        blink_s    = blink_r;
        err_bits_s = err_bits_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_WAIT;
                    to_cnt_s = {TW{1'b0}};
                    blink_s  = {BLINK_DIV{1'b0}};
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Re-arm beats a coincident strobe; a strobe beats the timeout.
                if (start) begin
                    to_cnt_s = {TW{1'b0}};
                    blink_s  = {BLINK_DIV{1'b0}};
                end else if (result_valid) begin
                    err_bits_s = diff_pop_s;
                    if (diff_pop_s == 8'd0) begin
                        state_s = ST_PASS;
                    end else begin
                        state_s = ST_FAIL;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    state_s = ST_TIMEOUT;
                end else begin
                    to_cnt_s = to_cnt_r + TW'(1);
                    blink_s  = blink_r + BLINK_DIV'(1);
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (start) begin
                    state_s  = ST_WAIT;
                    to_cnt_s = {TW{1'b0}};
                    blink_s  = {BLINK_DIV{1'b0}};
                end else begin
                    state_s  = state_r;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                to_cnt_s = {TW{1'b0}};
                blink_s  = {BLINK_DIV{1'b0}};
            end
        endcase

        done_s = 1'b0;
        pass_s = 1'b0;
        led1_s = 1'b0;
        led2_s = 1'b0;
        led3_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                led3_s = 1'b0;
            end
            ST_WAIT: begin
                led3_s = blink_s[BLINK_DIV-1];
            end
            ST_PASS: begin
                done_s = 1'b1;
                pass_s = 1'b1;
                led1_s = 1'b1;
            end
            ST_FAIL: begin
                done_s = 1'b1;
                led2_s = 1'b1;
            end
            ST_TIMEOUT: begin
                done_s = 1'b1;
                led3_s = 1'b1;
            end
            default: begin
                led3_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            to_cnt_r   <= {TW{1'b0}};
            blink_r    <= {BLINK_DIV{1'b0}};
            err_bits_r <= 8'd0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            led1_r     <= 1'b0;
            led2_r     <= 1'b0;
            led3_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            to_cnt_r   <= to_cnt_s;
            blink_r    <= blink_s;
            err_bits_r <= err_bits_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            led1_r     <= led1_s;
            led2_r     <= led2_s;
            led3_r     <= led3_s;
        end
    end

    assign done     = done_r;
    assign pass     = pass_r;
    assign err_bits = err_bits_r;
    assign led1     = led1_r;
    assign led2     = led2_r;
    assign led3     = led3_r;

endmodule

// File: tb/tb_aes_result_checker.sv
// -----------------------------------------------------------------------------
// tb_aes_result_checker
//
// Directed bench for aes_result_checker with TIMEOUT_CYCLES=16 and BLINK_DIV=3.
// Each step drives the inputs and pushes the expected output vector
// {done, pass, err_bits, led1, led2, led3} into a queue. After the next rising
// edge the step pops that vector and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_aes_result_checker;

    localparam logic [127:0] E = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] result;
    logic         result_valid;
    logic         done;
    logic         pass;
    logic [7:0]   err_bits;
    logic         led1;
    logic         led2;
    logic         led3;

    int vectors     = 0;
    int miscompares = 0;

    logic [12:0] exp_q[$];

    aes_result_checker #(
        .EXPECTED       (E),
        .TIMEOUT_CYCLES (16),
        .BLINK_DIV      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .result       (result),
        .result_valid (result_valid),
        .done         (done),
        .pass         (pass),
        .err_bits     (err_bits),
        .led1         (led1),
        .led2         (led2),
        .led3         (led3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the expected outputs in the same order as the observed vector.
    function automatic logic [12:0] ov(input logic d, input logic p, input logic [7:0] e,
                                       input logic l1, input logic l2, input logic l3);
        return {d, p, e, l1, l2, l3};
    endfunction

    // led3 while waiting with BLINK_DIV=3, k edges after the arm edge.
    function automatic logic blink(input int k);
        return ((k % 8) >= 4) ? 1'b1 : 1'b0;
    endfunction

    task automatic step(input logic r, input logic s, input logic v,
                        input logic [127:0] d, input logic [12:0] e, input string tag);
        logic [12:0] obs;
        logic [12:0] expv;
        rst          = r;
        start        = s;
        result_valid = v;
        result       = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs  = {done, pass, err_bits, led1, led2, led3};
        expv = exp_q.pop_front();
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_run(input int k0, input int k1, input logic [7:0] e, input string tag);
        for (int k = k0; k <= k1; k++) begin
            step(1'b1, 1'b0, 1'b0, 128'd0, ov(1'b0, 1'b0, e, 1'b0, 1'b0, blink(k)), tag);
        end
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        result_valid = 1'b0;
        result       = 128'd0;

        // Reset state, then a strobe in IDLE without start is ignored.
        step(1'b0, 1'b0, 1'b0, 128'd0, 13'd0, "reset0");
        step(1'b0, 1'b0, 1'b1, E, 13'd0, "reset_valid");
        step(1'b1, 1'b0, 1'b1, E ^ 128'h1, 13'd0, "idle_ignore");

        // Pass case: strobe 10 cycles after the arm, blink observed meanwhile.
        step(1'b1, 1'b1, 1'b0, 128'd0, ov(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0), "arm1");
        wait_run(1, 9, 8'd0, "wait_blink");
        step(1'b1, 1'b0, 1'b1, E, ov(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0), "pass");
        step(1'b1, 1'b0, 1'b1, E ^ 128'h1, ov(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0), "pass_sticky");

        // Fail cases: single-bit error, then all bits wrong after re-arm.
        step(1'b1, 1'b1, 1'b0, 128'd0, ov(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0), "arm2");
        wait_run(1, 3, 8'd0, "wait2");
        step(1'b1, 1'b0, 1'b1, E ^ 128'h1, ov(1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0), "fail_1bit");
        step(1'b1, 1'b1, 1'b0, 128'd0, ov(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0), "rearm_err_hold");
        step(1'b1, 1'b0, 1'b1, ~E, ov(1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0), "fail_all");

        // Timeout: arm at edge 0, done and steady led3 only after edge 15.
        step(1'b1, 1'b1, 1'b0, 128'd0, ov(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0), "arm_to");
        wait_run(1, 14, 8'h80, "to_wait");
        step(1'b1, 1'b0, 1'b0, 128'd0, ov(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1), "timeout");
        step(1'b1, 1'b0, 1'b1, E, ov(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1), "late_valid");
        step(1'b1, 1'b0, 1'b0, 128'd0, ov(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1), "to_sticky");

        // A matching strobe exactly on the timeout cycle wins.
        step(1'b1, 1'b1, 1'b0, 128'd0, ov(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0), "arm_prio");
        wait_run(1, 14, 8'h80, "prio_wait");
        step(1'b1, 1'b0, 1'b1, E, ov(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0), "valid_on_timeout");

        // start with result_valid re-arms mid-blink; the pattern restarts at 0.
        step(1'b1, 1'b1, 1'b0, 128'd0, ov(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0), "arm3");
        wait_run(1, 5, 8'd0, "pre_rearm");
        step(1'b1, 1'b1, 1'b1, E ^ 128'h1, ov(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0), "start_beats_valid");
        wait_run(1, 4, 8'd0, "post_rearm");

        // Reset during WAIT drops a coincident strobe; then no start means no change.
        step(1'b0, 1'b0, 1'b1, E, 13'd0, "rst_wait");
        step(1'b1, 1'b0, 1'b1, E, 13'd0, "no_start_after_rst");

        // Reset during PASS.
        step(1'b1, 1'b1, 1'b0, 128'd0, 13'd0, "arm4");
        step(1'b1, 1'b0, 1'b1, E, ov(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0), "pass2");
        step(1'b0, 1'b0, 1'b0, 128'd0, 13'd0, "rst_pass");
        step(1'b1, 1'b0, 1'b1, E ^ 128'h1, 13'd0, "idle_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
